// File: rtl/psec6_spi_cmd_decoder_pkg.sv
// Shared types for the PSEC6 SPI command decoder.
//   opcode_t   : 4-bit command opcode carried in frame bits [15:12]
//   ro_state_t : readout window state
//   smode_t    : broadcast sampling mode
//   FRAME_LEN  : bits per SPI command frame
package psec6_spi_cmd_decoder_pkg;

  localparam int unsigned FRAME_LEN = 16;

  typedef logic [1:0] smode_t;

  typedef enum logic [3:0] {
    OP_NOP     = 4'h0,
    OP_WR_MODE = 4'h1,
    OP_WR_POL  = 4'h2,
    OP_START   = 4'h3,
    OP_READOUT = 4'h4,
    OP_CLR_ERR = 4'h5
  } opcode_t;

  typedef enum logic {
    RO_IDLE   = 1'b0,
    RO_ACTIVE = 1'b1
  } ro_state_t;

  // Commands that would disturb channel configuration or CH_SEL while a
  // readout window is open; they are rejected during RO_ACTIVE.
  function automatic logic locked_during_readout(input opcode_t op);
    return (op == OP_START) || (op == OP_WR_MODE) ||
           (op == OP_WR_POL) || (op == OP_READOUT);
  endfunction

endpackage

// File: rtl/psec6_spi_cmd_decoder_spi_frame_rx.sv
// SPI frame receiver: shifts MOSI in MSB first while csb is low and
// presents each completed 16-bit frame for one cycle.
//   clk, rst    : SPI clock, async active-high reset
//   csb, mosi   : frame select (active low), serial data
//   frame_valid : high in the cycle whose rising edge captures bit 0
//   frame_word  : assembled frame, valid with frame_valid
//   frame_err   : csb raised with a partial frame (1..15 bits) in flight
module psec6_spi_cmd_decoder_spi_frame_rx
  import psec6_spi_cmd_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csb,
  input  logic                 mosi,
  output logic                 frame_valid,
  output logic [FRAME_LEN-1:0] frame_word,
  output logic                 frame_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);

  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_LEN-2:0] shreg;

  // The counter wraps 15->0 on the decode edge, so with csb held low the
  // next bit is bit 15 of a new frame; a frame can never exceed 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (csb) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      bit_cnt <= bit_cnt + CNT_W'(1);
      shreg   <= {shreg[FRAME_LEN-3:0], mosi};
    end
  end

  // The last bit is taken straight from mosi so the decode lands on the
  // same edge that captures it.
  assign frame_word  = {shreg, mosi};
  assign frame_valid = !csb && (bit_cnt == CNT_W'(FRAME_LEN - 1));
  assign frame_err   = csb && (bit_cnt != '0);

endmodule

// File: rtl/psec6_spi_cmd_decoder.sv
// PSEC6 chip-level SPI command decoder and readout steering.
//   SPI_CLK, RST            : clock, async active-high reset
//   SPI_CSB, SPI_MOSI       : command frame select / data
//   CNT_SER                 : per-channel serial readout bits
//   SPI_MISO                : selected CNT_SER bit during readout window
//   INST_START              : one-cycle start strobe
//   INST_READOUT            : readout enable, READ_LEN cycles
//   MODE                    : sampling mode
//   DISCRIMINATOR_POLARITY  : per-channel polarity
//   SELECT_REG, CH_SEL      : readout register / channel select
//   FRAME_ERR               : sticky protocol error
module psec6_spi_cmd_decoder
  import psec6_spi_cmd_decoder_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned READ_LEN = 10
) (
  input  logic                      SPI_CLK,
  input  logic                      RST,
  input  logic                      SPI_CSB,
  input  logic                      SPI_MOSI,
  input  logic [NUM_CH-1:0]         CNT_SER,
  output logic                      SPI_MISO,
  output logic                      INST_START,
  output logic                      INST_READOUT,
  output smode_t                    MODE,
  output logic [NUM_CH-1:0]         DISCRIMINATOR_POLARITY,
  output logic [2:0]                SELECT_REG,
  output logic [$clog2(NUM_CH)-1:0] CH_SEL,
  output logic                      FRAME_ERR
);

  localparam int unsigned CH_W     = $clog2(NUM_CH);
  localparam int unsigned RO_CNT_W = $clog2(READ_LEN + 1);

  logic                 frame_valid;
  logic [FRAME_LEN-1:0] frame_word;
  logic                 rx_err;

  opcode_t       op;
  logic [7:0]    data;
  logic          op_known;
  logic          busy;
  logic          blocked;
  logic          accept;
  logic          err_set;
  logic          ro_start;
  logic          miso_en;
  logic          unused_reserved;

  ro_state_t             ro_state, ro_next;
  logic [RO_CNT_W-1:0]   ro_cnt;

  psec6_spi_cmd_decoder_spi_frame_rx u_rx (
    .clk         (SPI_CLK),
    .rst         (RST),
    .csb         (SPI_CSB),
    .mosi        (SPI_MOSI),
    .frame_valid (frame_valid),
    .frame_word  (frame_word),
    .frame_err   (rx_err)
  );

  assign op              = opcode_t'(frame_word[15:12]);
  assign data            = frame_word[7:0];
  assign unused_reserved = ^frame_word[11:8];

  assign op_known = (frame_word[15:12] <= 4'h5);
  assign blocked  = busy && locked_during_readout(op);
  assign accept   = frame_valid && op_known && !blocked;
  assign err_set  = rx_err || (frame_valid && (!op_known || blocked));
  assign ro_start = accept && (op == OP_READOUT);

  // Readout FSM: state register
  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) ro_state <= RO_IDLE;
    else     ro_state <= ro_next;
  end

  // Readout FSM: next state
  always_comb begin
    ro_next = ro_state;
    case (ro_state)
      RO_IDLE:   if (ro_start) ro_next = RO_ACTIVE;
      RO_ACTIVE: if (ro_cnt == RO_CNT_W'(1)) ro_next = RO_IDLE;
      default:   ro_next = RO_IDLE;
    endcase
  end

  // Readout FSM: outputs
  always_comb begin
    INST_READOUT = (ro_state == RO_ACTIVE);
    busy         = (ro_state == RO_ACTIVE);
  end

  // Window length counter; runs off SPI_CLK independent of SPI_CSB.
  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST)           ro_cnt <= '0;
    else if (ro_start) ro_cnt <= RO_CNT_W'(READ_LEN);
    else if (busy)     ro_cnt <= ro_cnt - RO_CNT_W'(1);
  end

  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) begin
      INST_START             <= 1'b0;
      MODE                   <= '0;
      DISCRIMINATOR_POLARITY <= '0;
      SELECT_REG             <= '0;
      CH_SEL                 <= '0;
      FRAME_ERR              <= 1'b0;
      miso_en                <= 1'b0;
    end else begin
      INST_START <= 1'b0;
      miso_en    <= INST_READOUT;
      // A fresh error outranks a simultaneous CLR_ERR.
      if (err_set)
        FRAME_ERR <= 1'b1;
      else if (accept && (op == OP_CLR_ERR))
        FRAME_ERR <= 1'b0;
      if (accept) begin
        case (op)
          OP_WR_MODE: MODE                   <= data[1:0];
          OP_WR_POL:  DISCRIMINATOR_POLARITY <= data[NUM_CH-1:0];
          OP_START:   INST_START             <= 1'b1;
          OP_READOUT: begin
            CH_SEL     <= CH_W'(data[5:3]);
            SELECT_REG <= data[2:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign SPI_MISO = CNT_SER[CH_SEL] & miso_en;

endmodule

// File: tb/tb_psec6_spi_cmd_decoder.sv
module tb_psec6_spi_cmd_decoder;
  import psec6_spi_cmd_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       csb;
  logic       mosi;
  logic [7:0] cnt_ser;

  logic       miso, start, readout, err;
  smode_t     mode;
  logic [7:0] pol;
  logic [2:0] sel, ch;

  // Second instance with a window longer than a frame, so a command can
  // complete while its readout window is still open.
  logic       l_miso, l_start, l_readout, l_err;
  smode_t     l_mode;
  logic [7:0] l_pol;
  logic [2:0] l_sel, l_ch;

  int n_checks = 0;
  int n_fail   = 0;

  logic mon_en = 1'b0;
  int   ro_long_cnt;
  int   start_long_seen;

  typedef struct {
    logic [15:0] word;
    smode_t      mode;
    logic [7:0]  pol;
    logic        err;
    logic        start;
  } vec_t;

  vec_t vecs[10];

  psec6_spi_cmd_decoder #(.NUM_CH(8), .READ_LEN(10)) dut (
    .SPI_CLK(clk), .RST(rst), .SPI_CSB(csb), .SPI_MOSI(mosi),
    .CNT_SER(cnt_ser), .SPI_MISO(miso), .INST_START(start),
    .INST_READOUT(readout), .MODE(mode), .DISCRIMINATOR_POLARITY(pol),
    .SELECT_REG(sel), .CH_SEL(ch), .FRAME_ERR(err)
  );

  psec6_spi_cmd_decoder #(.NUM_CH(8), .READ_LEN(24)) dut_long (
    .SPI_CLK(clk), .RST(rst), .SPI_CSB(csb), .SPI_MOSI(mosi),
    .CNT_SER(cnt_ser), .SPI_MISO(l_miso), .INST_START(l_start),
    .INST_READOUT(l_readout), .MODE(l_mode), .DISCRIMINATOR_POLARITY(l_pol),
    .SELECT_REG(l_sel), .CH_SEL(l_ch), .FRAME_ERR(l_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!mon_en) begin
      ro_long_cnt     = 0;
      start_long_seen = 0;
    end else begin
      if (l_readout) ro_long_cnt++;
      if (l_start)   start_long_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    @(negedge clk);
    csb  = 1'b0;
    mosi = b;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      csb  = 1'b1;
      mosi = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bit_out(w[i]);
  endtask

  initial begin
    logic [9:0]  pat;
    logic [15:0] w;
    logic        b;

    rst = 1'b1; csb = 1'b1; mosi = 1'b0; cnt_ser = '1;

    vecs[0] = '{16'h1003, 2'd3, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{16'h20A5, 2'd3, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{16'h3000, 2'd3, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{16'h1102, 2'd2, 8'hA5, 1'b0, 1'b0};
    vecs[4] = '{16'h6000, 2'd2, 8'hA5, 1'b1, 1'b0};
    vecs[5] = '{16'h2C3C, 2'd2, 8'h3C, 1'b1, 1'b0};
    vecs[6] = '{16'h5000, 2'd2, 8'h3C, 1'b0, 1'b0};
    vecs[7] = '{16'hF0FF, 2'd2, 8'h3C, 1'b1, 1'b0};
    vecs[8] = '{16'h5000, 2'd2, 8'h3C, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 2'd2, 8'h3C, 1'b0, 1'b0};

    // Reset, then RST mid-frame
    idle(3);
    rst = 1'b0;
    idle(1);
    #1;
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    send_word(16'h20FF);
    idle(1);
    #1;
    check("pre_reset_pol", 32'(pol), 32'hFF);
    w = 16'h1003;
    for (int i = 15; i >= 7; i--) bit_out(w[i]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_pol", 32'(pol), 32'd0);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_readout", 32'(readout), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_sel", 32'({ch, sel}), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    #1;
    check("postrst_err", 32'(err), 32'd0);
    check("postrst_mode", 32'(mode), 32'd0);

    // Table-driven single frames
    for (int i = 0; i < 10; i++) begin
      send_word(vecs[i].word);
      idle(1);
      #1;
      check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].mode));
      check($sformatf("vec%0d_pol", i), 32'(pol), 32'(vecs[i].pol));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("vec%0d_start", i), 32'(start), 32'(vecs[i].start));
      check($sformatf("vec%0d_readout", i), 32'(readout), 32'd0);
      check($sformatf("vec%0d_miso", i), 32'(miso), 32'd0);
    end

    // START pulse is exactly one cycle
    send_word(16'h3000);
    idle(1);
    #1;
    check("start_pulse_hi", 32'(start), 32'd1);
    idle(1);
    #1;
    check("start_pulse_lo", 32'(start), 32'd0);

    // Readout channel 5, register 3, with other channels driven opposite
    pat = 10'b1011001110;
    send_word(16'h402B);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      csb = 1'b1;
      if (k >= 1 && k <= 10) begin
        b = pat[10-k];
        cnt_ser = {8{~b}};
        cnt_ser[5] = b;
      end else begin
        cnt_ser = '1;
      end
      #1;
      check($sformatf("ro_readout_k%0d", k), 32'(readout), (k < 10) ? 32'd1 : 32'd0);
      check($sformatf("ro_miso_k%0d", k), 32'(miso),
            (k >= 1 && k <= 10) ? 32'(pat[10-k]) : 32'd0);
    end
    check("ro_ch_sel", 32'(ch), 32'd5);
    check("ro_select_reg", 32'(sel), 32'd3);
    check("ro_err", 32'(err), 32'd0);

    // Short frame: 9 bits then CSB high
    w = 16'h1001;
    for (int i = 15; i >= 7; i--) bit_out(w[i]);
    idle(2);
    #1;
    check("short_err", 32'(err), 32'd1);
    check("short_mode", 32'(mode), 32'd2);
    send_word(16'h5000);
    idle(1);
    #1;
    check("clr_err", 32'(err), 32'd0);

    // Back-to-back frames with CSB low for 32 bits
    send_word(16'h1001);
    w = 16'h3000;
    for (int i = 15; i >= 0; i--) begin
      bit_out(w[i]);
      if (i == 15) begin
        #1;
        check("b2b_mode", 32'(mode), 32'd1);
        check("b2b_no_early_start", 32'(start), 32'd0);
      end
    end
    idle(1);
    #1;
    check("b2b_start", 32'(start), 32'd1);
    check("b2b_err", 32'(err), 32'd0);
    idle(1);
    #1;
    check("b2b_start_lo", 32'(start), 32'd0);

    // START arriving during an open readout window (long instance)
    idle(30);
    send_word(16'h5000);
    idle(1);
    #1;
    check("long_pre_err", 32'(l_err), 32'd0);
    mon_en = 1'b1;
    send_word(16'h402B);
    send_word(16'h3000);
    idle(1);
    #1;
    check("short_win_start", 32'(start), 32'd1);
    check("long_blocked_err", 32'(l_err), 32'd1);
    idle(30);
    mon_en = 1'b0;
    check("long_ro_len", 32'(ro_long_cnt), 32'd24);
    check("long_no_start", 32'(start_long_seen), 32'd0);
    check("long_ch_sel", 32'(l_ch), 32'd5);
    check("short_err_clean", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
